// File: rtl/xband_pkg.sv
// Shared types and helpers for the Xband AXI-Stream test frame source.
// State encoding, PRBS-31 tap positions and final-beat byte-enable decode.
package xband_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} src_state_t;

  localparam int PRBS31_TAP_A = 31;
  localparam int PRBS31_TAP_B = 28;

  // Byte enables of the final beat from the frame length modulo 4.
  function automatic logic [3:0] keep_from_rem(input logic [1:0] rem);
    case (rem)
      2'd1:    keep_from_rem = 4'h1;
      2'd2:    keep_from_rem = 4'h3;
      2'd3:    keep_from_rem = 4'h7;
      default: keep_from_rem = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/xband_prbs32.sv
// PRBS-31 (x^31+x^28+1) generator producing 32 output bits per step, first bit in o_dat[0].
// o_dat is the word for the present state (or for SEED while i_load is high); load/advance move the state past it.
module xband_prbs32
  import xband_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h7FFF_FFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [31:0] o_dat
);

  logic [30:0] r_state;
  logic [30:0] w_next;

  always_comb begin
    logic [30:0] v_s;
    logic        v_fb;
    o_dat  = '0;
    v_fb   = 1'b0;
    v_s    = i_load ? SEED[30:0] : r_state;
    for (int i = 0; i < 32; i++) begin
      v_fb     = v_s[PRBS31_TAP_A-1] ^ v_s[PRBS31_TAP_B-1];
      o_dat[i] = v_fb;
      v_s      = {v_s[29:0], v_fb};
    end
    w_next = v_s;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= SEED[30:0];
    end else if (i_load || i_adv) begin
      r_state <= w_next;
    end
  end

endmodule

// File: rtl/xband_axis_frame_src.sv
// AXI4-Stream frame source: one expBytes-long pattern frame per new_frame rising edge, then a forced idle gap.
// Define XBAND_SRC_PRBS_EN for PRBS-31 payload instead of the byte counter; beats hold while tready is low.
module xband_axis_frame_src
  import xband_pkg::*;
#(
  parameter int          GAP_CYCLES  = 16,
  parameter int          FRAME_CNT_W = 16,
  parameter logic [31:0] PRBS_SEED   = 32'h7FFF_FFFF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   enable,
  input  logic                   new_frame,
  input  logic [31:0]            expBytes,
  output logic [31:0]            m_axis_tdata,
  output logic [3:0]             m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   frame_drop,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (GAP_CYCLES < 1 || PRBS_SEED[30:0] == 31'd0) begin : g_bad_param
    $error("xband_axis_frame_src: GAP_CYCLES must be >= 1 and PRBS_SEED[30:0] nonzero");
  end

  src_state_t       r_state;
  logic             r_new_frame_d;
  logic [30:0]      r_rem;
  logic [3:0]       r_last_keep;
  logic [GAP_W-1:0] r_gap;

  logic        w_rise, w_start, w_hs, w_adv;
  logic [30:0] w_words;
  logic [3:0]  w_keep0;
  logic [31:0] w_first_dat, w_next_dat;

  assign w_rise  = new_frame & ~r_new_frame_d;
  assign w_start = (r_state == IDLE) & w_rise & enable & (expBytes != 32'd0);
  assign w_hs    = m_axis_tvalid & m_axis_tready;
  assign w_adv   = w_hs & ~m_axis_tlast;
  assign w_words = {1'b0, expBytes[31:2]} + {30'd0, |expBytes[1:0]};
  assign w_keep0 = keep_from_rem(expBytes[1:0]);
  assign busy    = (r_state != IDLE);

`ifdef XBAND_SRC_PRBS_EN
  logic [31:0] w_prbs_dat;

  xband_prbs32 #(.SEED(PRBS_SEED)) u_prbs (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_load  (w_start),
    .i_adv   (w_hs),
    .o_dat   (w_prbs_dat)
  );

  assign w_first_dat = w_prbs_dat;
  assign w_next_dat  = w_prbs_dat;
`else
  // r_base is the frame byte index of the beat currently on the bus.
  logic [7:0] r_base;
  logic [7:0] w_base_nxt;

  assign w_base_nxt  = r_base + 8'd4;
  assign w_first_dat = 32'h0302_0100;
  assign w_next_dat  = {w_base_nxt + 8'd3, w_base_nxt + 8'd2, w_base_nxt + 8'd1, w_base_nxt};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_base <= '0;
    end else if (w_start) begin
      r_base <= '0;
    end else if (w_adv) begin
      r_base <= w_base_nxt;
    end
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_new_frame_d <= 1'b0;
      r_rem         <= '0;
      r_last_keep   <= '0;
      r_gap         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_drop    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      r_new_frame_d <= new_frame;
      frame_drop    <= w_rise & (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state       <= SEND;
            r_rem         <= w_words - 31'd1;
            r_last_keep   <= w_keep0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_first_dat;
            m_axis_tlast  <= (w_words == 31'd1);
            m_axis_tkeep  <= (w_words == 31'd1) ? w_keep0 : 4'hF;
          end
        end
        SEND: begin
          if (w_hs && m_axis_tlast) begin
            r_state       <= GAP;
            r_gap         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            frame_cnt     <= frame_cnt + 1'b1;
          end else if (w_hs) begin
            // r_rem counts beats still to come after the one on the bus.
            r_rem        <= r_rem - 31'd1;
            m_axis_tdata <= w_next_dat;
            m_axis_tlast <= (r_rem == 31'd1);
            m_axis_tkeep <= (r_rem == 31'd1) ? r_last_keep : 4'hF;
          end
        end
        GAP: begin
          if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xband_axis_frame_src.sv
// Directed bench for xband_axis_frame_src: frame-level scoreboard checked every cycle plus literal spot checks.
module tb_xband_axis_frame_src;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic        new_frame = 1'b0;
  logic [31:0] expBytes = '0;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, busy, frame_drop;
  logic [15:0] frame_cnt;

  xband_axis_frame_src dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .enable        (enable),
    .new_frame     (new_frame),
    .expBytes      (expBytes),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .busy          (busy),
    .frame_drop    (frame_drop),
    .frame_cnt     (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] model_cnt = '0;
  int          hs_cnt = 0, last_cnt = 0, drop_cnt = 0;
  logic [31:0] log_d[0:255];
  logic [3:0]  last_keep_seen = '0;
  logic        rand_rdy = 1'b0;
  logic        p_vld = 1'b0, p_hs = 1'b0, p_last = 1'b0;
  logic [31:0] p_d = '0;
  logic [3:0]  p_k = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected beats of one frame, built byte by byte from the frame length.
  function automatic void push_frame(input int nbytes);
    beat_t       b;
    logic [30:0] s;
    logic        bit_o;
    s = 31'h7FFF_FFFF;
    for (int n = 0; n < nbytes; n += 4) begin
      b.d = '0;
`ifdef XBAND_SRC_PRBS_EN
      for (int i = 0; i < 32; i++) begin
        bit_o  = s[30] ^ s[27];
        b.d[i] = bit_o;
        s      = {s[29:0], bit_o};
      end
`else
      for (int j = 0; j < 4; j++) b.d[8*j +: 8] = 8'(n + j);
`endif
      b.l = (n + 4 >= nbytes);
      case (nbytes - n)
        1:       b.k = 4'h1;
        2:       b.k = 4'h3;
        3:       b.k = 4'h7;
        default: b.k = 4'hF;
      endcase
      exp_q.push_back(b);
    end
  endfunction

  // Compare process: outputs sampled on the falling edge.
  always @(negedge sys_clk) begin
    logic hs;
    if (sys_rst) begin
      exp_q.delete();
      model_cnt = '0;
      p_vld = 1'b0; p_hs = 1'b0; p_last = 1'b0;
    end else begin
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, model_cnt});
      if (p_vld && !(p_hs && p_last)) check("no_bubble_tvalid", {31'd0, tvalid}, 32'd1);
      if (p_hs && p_last) check("tvalid_after_last", {31'd0, tvalid}, 32'd0);
      if (p_vld && !p_hs) begin
        check("stall_tdata", tdata, p_d);
        check("stall_tkeep", {28'd0, tkeep}, {28'd0, p_k});
        check("stall_tlast", {31'd0, tlast}, {31'd0, p_last});
      end
      if (tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_tvalid", {31'd0, tvalid}, 32'd0);
        end else begin
          check("tdata", tdata, exp_q[0].d);
          check("tkeep", {28'd0, tkeep}, {28'd0, exp_q[0].k});
          check("tlast", {31'd0, tlast}, {31'd0, exp_q[0].l});
        end
      end
      if (frame_drop) drop_cnt++;
      hs = tvalid & tready;
      if (hs && exp_q.size() != 0) begin
        log_d[hs_cnt % 256] = tdata;
        hs_cnt++;
        if (tlast) begin
          last_cnt++;
          last_keep_seen = tkeep;
        end
        if (exp_q[0].l) model_cnt = model_cnt + 16'd1;
        void'(exp_q.pop_front());
      end
      p_vld = tvalid; p_hs = hs; p_last = tlast; p_d = tdata; p_k = tkeep;
    end
  end

  always @(posedge sys_clk) begin
    if (rand_rdy) begin
      #1;
      tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse();
    new_frame = 1'b1;
    tick(1);
    new_frame = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick(1);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int base, hbase, lbase, dbase;
    bit ok;
    logic [31:0] fa[0:2];
    tick(3);
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_tkeep", {28'd0, tkeep}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    sys_rst = 1'b0; enable = 1'b1; tready = 1'b1;
    tick(2);

    // 10-byte frame.
    base = hs_cnt;
    push_frame(10); expBytes = 32'd10; pulse(); wait_done("f10");
`ifndef XBAND_SRC_PRBS_EN
    check("f10_beat0", log_d[base % 256], 32'h0302_0100);
    check("f10_beat1", log_d[(base + 1) % 256], 32'h0706_0504);
    check("f10_beat2", log_d[(base + 2) % 256], 32'h0B0A_0908);
`endif
    check("f10_beats", hs_cnt - base, 32'd3);
    check("f10_last_keep", {28'd0, last_keep_seen}, 32'h3);
    check("f10_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 4-byte frame: a single full beat.
    base = hs_cnt;
    push_frame(4); expBytes = 32'd4; pulse(); wait_done("f4");
`ifndef XBAND_SRC_PRBS_EN
    check("f4_beat0", log_d[base % 256], 32'h0302_0100);
`endif
    check("f4_beats", hs_cnt - base, 32'd1);
    check("f4_last_keep", {28'd0, last_keep_seen}, 32'hF);

    // Ignored requests: zero length, then enable low.
    dbase = drop_cnt;
    expBytes = 32'd0; pulse(); tick(30);
    check("zero_len_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0; expBytes = 32'd8; pulse(); tick(30);
    check("disabled_busy", {31'd0, busy}, 32'd0);
    check("ignored_drops", drop_cnt - dbase, 32'd0);
    check("ignored_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    enable = 1'b1;

    // 64 bytes under random backpressure.
    hbase = hs_cnt; lbase = last_cnt;
    push_frame(64); expBytes = 32'd64; rand_rdy = 1'b1; pulse(); wait_done("f64");
    rand_rdy = 1'b0; tick(1); tready = 1'b1;
    check("f64_beats", hs_cnt - hbase, 32'd16);
    check("f64_lasts", last_cnt - lbase, 32'd1);

    // Requests during SEND and GAP are dropped.
    dbase = drop_cnt; hbase = hs_cnt;
    push_frame(40); expBytes = 32'd40; pulse(); tick(2); pulse();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("drop_send_timeout", 32'd1, 32'd0);
    tick(5); pulse(); wait_done("drop");
    check("drop_pulses", drop_cnt - dbase, 32'd2);
    check("drop_beats", hs_cnt - hbase, 32'd10);
    check("drop_frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // Reset while beat 3 of a 20-beat frame is on the bus.
    hbase = hs_cnt;
    push_frame(80); expBytes = 32'd80; pulse();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (hs_cnt - hbase == 3) ok = 1'b1;
      else tick(1);
    end
    if (!ok) check("rst_mid_timeout", 32'd1, 32'd0);
    sys_rst = 1'b1;
    #1;
    check("rst_mid_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_mid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    tick(2); sys_rst = 1'b0; tick(2);
    base = hs_cnt;
    push_frame(8); expBytes = 32'd8; pulse(); wait_done("after_rst");
`ifndef XBAND_SRC_PRBS_EN
    check("after_rst_beat0", log_d[base % 256], 32'h0302_0100);
`endif
    check("after_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

`ifdef XBAND_SRC_PRBS_EN
    // Same length twice must repeat the same PRBS words.
    base = hs_cnt;
    push_frame(12); expBytes = 32'd12; pulse(); wait_done("prbs_a");
    for (int i = 0; i < 3; i++) fa[i] = log_d[(base + i) % 256];
    base = hs_cnt;
    push_frame(12); pulse(); wait_done("prbs_b");
    for (int i = 0; i < 3; i++) check("prbs_repeat", log_d[(base + i) % 256], fa[i]);
`else
    fa[0] = '0; fa[1] = '0; fa[2] = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
